// File: rtl/delay_line_ctrl_if.sv
// Control/status bundle between the host, the delay-line sequencer and the datapath.
// The master side issues delay requests and pacing; the slave side drives the line.
interface delay_line_ctrl_if #(
  parameter int AW    = 3,
  parameter int DIV_W = 8
);
  logic             run_en;
  logic [DIV_W-1:0] div;
  logic             cfg_req;
  logic [AW-1:0]    cfg_delay;
  logic             cfg_ack;
  logic             line_clr;
  logic [AW-1:0]    line_addr;
  logic             shift_en;
  logic             dout_valid;
  logic             busy;

  modport master (
    output run_en, div, cfg_req, cfg_delay,
    input  cfg_ack, line_clr, line_addr, shift_en, dout_valid, busy
  );

  modport slave (
    input  run_en, div, cfg_req, cfg_delay,
    output cfg_ack, line_clr, line_addr, shift_en, dout_valid, busy
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Sequencer for a tapped serial delay line: paces shifts with a divider and runs a
// flush/refill sequence on every delay change so dout_valid only marks fresh taps.
module delay_line_ctrl #(
  parameter int DEPTH = 7,
  parameter int AW    = 3,
  parameter int DIV_W = 8
) (
  input logic              clk,
  input logic              clr,
  delay_line_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} state_t;

  localparam logic [AW-1:0] DMAX = AW'(DEPTH);

  state_t           state_q;
  logic [AW-1:0]    del_q;
  logic [AW-1:0]    fill_q;
  logic [AW-1:0]    line_addr_q;
  logic [DIV_W-1:0] cnt_q;
  logic             cfg_ack_q;
  logic             line_clr_q;
  logic             dout_valid_q;
  logic             busy_q;

  logic [AW-1:0]    del_d;
  logic             tick;
  logic             shift;
  logic             accept;

  always_comb begin
    del_d  = (bus.cfg_delay > DMAX) ? DMAX : bus.cfg_delay;
    // A zero-delay fill has nothing to shift in, so the divider stays parked there.
    tick   = bus.run_en && (state_q == RUN || (state_q == FILL && fill_q != '0));
    shift  = tick && (cnt_q == bus.div);
    accept = bus.cfg_req && (state_q == IDLE || state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= IDLE;
      del_q        <= '0;
      fill_q       <= '0;
      line_addr_q  <= '0;
      cnt_q        <= '0;
      cfg_ack_q    <= 1'b0;
      line_clr_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cfg_ack_q <= 1'b0;
      if (tick) begin
        cnt_q <= shift ? '0 : cnt_q + DIV_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          line_clr_q <= 1'b1;
        end
        FLUSH: begin
          line_clr_q <= 1'b1;
          fill_q     <= del_q;
          cnt_q      <= '0;
          state_q    <= FILL;
        end
        FILL: begin
          if (fill_q == '0 || (shift && fill_q == AW'(1))) begin
            state_q      <= RUN;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b1;
          end
          if (shift) begin
            fill_q <= fill_q - AW'(1);
          end
        end
        RUN: begin
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // Accepting from RUN overrides the RUN hold above; any shift this cycle still occurs.
      if (accept) begin
        del_q        <= del_d;
        line_addr_q  <= del_d;
        state_q      <= FLUSH;
        cfg_ack_q    <= 1'b1;
        line_clr_q   <= 1'b0;
        busy_q       <= 1'b1;
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cfg_ack    = cfg_ack_q;
  assign bus.line_clr   = line_clr_q;
  assign bus.line_addr  = line_addr_q;
  assign bus.shift_en   = shift;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: directed latency scenarios plus a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_delay_line_ctrl;
  localparam int DEPTH = 7;
  localparam int AW    = 3;
  localparam int DIV_W = 8;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  delay_line_ctrl_if #(.AW(AW), .DIV_W(DIV_W)) bus ();
  delay_line_ctrl_if #(.AW(AW), .DIV_W(DIV_W)) bus5 ();

  delay_line_ctrl #(.DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W)) u_dut (
    .clk(clk), .clr(clr), .bus(bus)
  );
  delay_line_ctrl #(.DEPTH(5), .AW(AW), .DIV_W(DIV_W)) u_dut5 (
    .clk(clk), .clr(clr), .bus(bus5)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] obs;
  assign obs = {bus.cfg_ack, bus.line_clr, bus.line_addr, bus.shift_en, bus.dout_valid, bus.busy};

  // Reference model: phase 0 idle, 1 flush, 2 filling/running; shifts are counted up
  // against the requested delay and spaced by the gap since the previous shift.
  int            m_ph;
  logic [AW-1:0] m_del;
  logic [7:0]    m_gap;
  int            m_shifts;
  logic          m_ack, m_lclr, m_valid, m_busy;
  logic [AW-1:0] m_addr;

  function automatic logic m_shift();
    return (m_ph == 2) && bus.run_en && (m_valid || m_del != 0) && (m_gap == bus.div);
  endfunction

  always @(posedge clk) begin : model
    logic sh;
    logic acc;
    sh  = m_shift();
    acc = 1'b0;
    if (!clr) begin
      m_ph = 0; m_del = '0; m_gap = '0; m_shifts = 0;
      m_ack = 0; m_lclr = 0; m_valid = 0; m_busy = 0; m_addr = '0;
    end else begin
      m_ack = 1'b0;
      case (m_ph)
        0: begin m_lclr = 1'b1; acc = bus.cfg_req; end
        1: begin m_lclr = 1'b1; m_ph = 2; m_gap = '0; m_shifts = 0; end
        default: begin
          if (!m_valid) begin
            if (m_del == 0) begin
              m_valid = 1'b1; m_busy = 1'b0;
            end else if (bus.run_en) begin
              if (sh) begin
                m_shifts++;
                m_gap = '0;
                if (m_shifts == int'(m_del)) begin m_valid = 1'b1; m_busy = 1'b0; end
              end else begin
                m_gap++;
              end
            end
          end else begin
            if (bus.run_en) m_gap = sh ? 8'd0 : m_gap + 8'd1;
            acc = bus.cfg_req;
          end
        end
      endcase
      if (acc) begin
        m_del  = (int'(bus.cfg_delay) > DEPTH) ? AW'(DEPTH) : bus.cfg_delay;
        m_ph   = 1; m_ack = 1'b1; m_lclr = 1'b0;
        m_addr = m_del; m_busy = 1'b1; m_valid = 1'b0;
      end
    end
  end

  // Issues one request and measures the sequence; -1 marks an expired bound.
  task automatic send_req(input logic [AW-1:0] d, output int ack_wait, output int lat,
                          output int shifts, output int ack_n, output int lclr_n);
    ack_wait = 0; lat = -1; shifts = 0; ack_n = 0; lclr_n = 0;
    @(negedge clk);
    bus.cfg_req = 1'b1; bus.cfg_delay = d;
    do begin
      @(posedge clk); #1; ack_wait++;
    end while (!bus.cfg_ack && ack_wait < 200);
    bus.cfg_req = 1'b0;
    if (!bus.cfg_ack) begin ack_wait = -1; return; end
    lat = 1; ack_n = 1; lclr_n = bus.line_clr ? 0 : 1;
    while (!bus.dout_valid && lat < 3000) begin
      @(negedge clk); if (bus.shift_en) shifts++;
      @(posedge clk); #1; lat++;
      if (bus.cfg_ack) ack_n++;
      if (!bus.line_clr) lclr_n++;
    end
    if (!bus.dout_valid) lat = -1;
  endtask

  task automatic test_reset();
    clr = 1'b0; bus.cfg_req = 1'b1; bus.cfg_delay = 3'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 8'h00) begin errors++; $display("FAIL reset_outputs cycle %0d got %b want 00000000", i, obs); end
    end
    @(negedge clk); bus.cfg_req = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 8'b0100_0000) begin errors++; $display("FAIL reset_release got %b want 01000000", obs); end
  endtask

  task automatic test_basic();
    int aw, lat, sh, an, ln;
    bus.div = '0;
    send_req(3'd3, aw, lat, sh, an, ln);
    checks++; if (aw !== 1) begin errors++; $display("FAIL basic_ack_wait got %0d want 1", aw); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++; if (sh !== 3) begin errors++; $display("FAIL basic_fill_shifts got %0d want 3", sh); end
    checks++; if (an !== 1) begin errors++; $display("FAIL basic_ack_width got %0d want 1", an); end
    checks++; if (ln !== 1) begin errors++; $display("FAIL basic_clr_width got %0d want 1", ln); end
    checks++; if (bus.line_addr !== 3'd3) begin errors++; $display("FAIL basic_addr got %0d want 3", bus.line_addr); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.dout_valid, bus.shift_en, bus.busy} !== 3'b110) begin
        errors++; $display("FAIL basic_run cycle %0d got %b want 110", i, {bus.dout_valid, bus.shift_en, bus.busy});
      end
    end
  endtask

  task automatic test_slow();
    int aw, lat, sh, an, ln, n;
    bus.div = 8'd2;
    send_req(3'd7, aw, lat, sh, an, ln);
    checks++; if (lat !== 2 + 7 * 3) begin errors++; $display("FAIL slow_latency got %0d want %0d", lat, 2 + 7 * 3); end
    checks++; if (sh !== 7) begin errors++; $display("FAIL slow_fill_shifts got %0d want 7", sh); end
    n = 0;
    for (int i = 0; i < 9; i++) begin @(negedge clk); if (bus.shift_en) n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL slow_cadence got %0d want 3", n); end
    send_req(3'd6, aw, lat, sh, an, ln);
    checks++; if (aw !== 1) begin errors++; $display("FAIL reflush_ack_wait got %0d want 1", aw); end
    checks++; if (bus.line_addr !== 3'd6) begin errors++; $display("FAIL reflush_addr got %0d want 6", bus.line_addr); end
    checks++; if (ln !== 1) begin errors++; $display("FAIL reflush_clr_width got %0d want 1", ln); end
    checks++; if (lat !== 2 + 6 * 3) begin errors++; $display("FAIL reflush_latency got %0d want %0d", lat, 2 + 6 * 3); end
  endtask

  task automatic test_zero();
    int aw, lat, sh, an, ln;
    bus.div = 8'd0;
    send_req(3'd0, aw, lat, sh, an, ln);
    checks++; if (lat !== 3) begin errors++; $display("FAIL zero_latency got %0d want 3", lat); end
    checks++; if (sh !== 0) begin errors++; $display("FAIL zero_fill_shifts got %0d want 0", sh); end
    checks++; if (bus.line_addr !== 3'd0) begin errors++; $display("FAIL zero_addr got %0d want 0", bus.line_addr); end
  endtask

  task automatic test_clamp();
    int n, lat;
    @(negedge clk);
    bus5.cfg_req = 1'b1; bus5.cfg_delay = 3'd7; n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus5.cfg_ack && n < 200);
    bus5.cfg_req = 1'b0;
    checks++; if (n !== 1) begin errors++; $display("FAIL clamp_ack_wait got %0d want 1", n); end
    checks++; if (bus5.line_addr !== 3'd5) begin errors++; $display("FAIL clamp_addr got %0d want 5", bus5.line_addr); end
    lat = 1;
    while (!bus5.dout_valid && lat < 500) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 7) begin errors++; $display("FAIL clamp_latency got %0d want 7", lat); end
  endtask

  task automatic test_hold_req();
    int n, lat, early;
    bus.div = 8'd1;
    @(negedge clk); bus.cfg_req = 1'b1; bus.cfg_delay = 3'd4; n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.cfg_ack && n < 200);
    bus.cfg_req = 1'b0;
    lat = 1; early = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    @(negedge clk); bus.cfg_req = 1'b1; bus.cfg_delay = 3'd2;
    while (!bus.dout_valid && lat < 500) begin
      @(posedge clk); #1; lat++;
      if (bus.cfg_ack) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL hold_early_ack got %0d want 0", early); end
    checks++; if (lat !== 2 + 4 * 2) begin errors++; $display("FAIL hold_first_latency got %0d want %0d", lat, 2 + 4 * 2); end
    @(posedge clk); #1;
    checks++; if (bus.cfg_ack !== 1'b1) begin errors++; $display("FAIL hold_ack_after_run got %b want 1", bus.cfg_ack); end
    checks++; if (bus.line_addr !== 3'd2) begin errors++; $display("FAIL hold_addr got %0d want 2", bus.line_addr); end
    bus.cfg_req = 1'b0;
    lat = 1;
    while (!bus.dout_valid && lat < 500) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 2 + 2 * 2) begin errors++; $display("FAIL hold_second_latency got %0d want %0d", lat, 2 + 2 * 2); end
  endtask

  task automatic test_freeze();
    int n, lat, fsh;
    bus.div = 8'd0;
    @(negedge clk); bus.cfg_req = 1'b1; bus.cfg_delay = 3'd6; n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.cfg_ack && n < 200);
    bus.cfg_req = 1'b0;
    lat = 1; fsh = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    bus.run_en = 1'b0;
    repeat (10) begin
      @(negedge clk); if (bus.shift_en) fsh++;
      @(posedge clk); #1; lat++;
    end
    bus.run_en = 1'b1;
    while (!bus.dout_valid && lat < 500) begin @(posedge clk); #1; lat++; end
    checks++; if (fsh !== 0) begin errors++; $display("FAIL freeze_shifts got %0d want 0", fsh); end
    checks++; if (lat !== 2 + 6 + 10) begin errors++; $display("FAIL freeze_latency got %0d want %0d", lat, 2 + 6 + 10); end
  endtask

  task automatic test_midreset();
    int n, sh, aw, lat, an, ln;
    bus.div = 8'd1;
    @(negedge clk); bus.cfg_req = 1'b1; bus.cfg_delay = 3'd5; n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.cfg_ack && n < 200);
    bus.cfg_req = 1'b0;
    sh = 0;
    repeat (5) begin
      @(negedge clk); if (bus.shift_en) sh++;
      @(posedge clk); #1;
    end
    checks++; if (sh !== 2) begin errors++; $display("FAIL midreset_pre_shifts got %0d want 2", sh); end
    @(negedge clk); clr = 1'b0; bus.cfg_req = 1'b1; bus.cfg_delay = 3'd4;
    @(posedge clk); #1;
    checks++; if (obs !== 8'h00) begin errors++; $display("FAIL midreset_outputs got %b want 00000000", obs); end
    @(negedge clk); clr = 1'b1; bus.cfg_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (obs !== 8'b0100_0000) begin errors++; $display("FAIL midreset_idle got %b want 01000000", obs); end
    bus.div = 8'd0;
    send_req(3'd3, aw, lat, sh, an, ln);
    checks++; if (lat !== 5) begin errors++; $display("FAIL midreset_rerun_latency got %0d want 5", lat); end
    checks++; if (sh !== 3) begin errors++; $display("FAIL midreset_rerun_shifts got %0d want 3", sh); end
    checks++; if (bus.line_addr !== 3'd3) begin errors++; $display("FAIL midreset_rerun_addr got %0d want 3", bus.line_addr); end
  endtask

  task automatic test_random();
    logic       hold;
    logic [7:0] exp;
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_ack) hold = 1'b0;
      if (!hold && $urandom_range(0, 19) == 0) begin
        hold = 1'b1; bus.cfg_delay = AW'($urandom_range(0, 7));
      end
      bus.cfg_req = hold;
      bus.run_en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) bus.div = DIV_W'($urandom_range(0, 3));
      clr = ($urandom_range(0, 299) != 0);
      #1;
      exp = {m_ack, m_lclr, m_addr, m_shift(), m_valid, m_busy};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random cycle %0d got %b want %b", i, obs, exp); end
    end
    @(negedge clk); clr = 1'b1; bus.cfg_req = 1'b0; bus.run_en = 1'b1;
  endtask

  initial begin
    clr = 1'b0;
    bus.run_en = 1'b1;  bus.div = '0;  bus.cfg_req = 1'b0;  bus.cfg_delay = '0;
    bus5.run_en = 1'b1; bus5.div = '0; bus5.cfg_req = 1'b0; bus5.cfg_delay = '0;
    test_reset();
    test_basic();
    test_slow();
    test_zero();
    test_clamp();
    test_hold_req();
    test_freeze();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
